// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: requests instructions at the current PC, hands them to
// decode over valid/ready, advances or redirects the PC and flags fetch errors.
module instr_fetch_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int PC_STEP = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  pc_write,
    output logic               pc_wen,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               dec_ready,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               fetch_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, REQ, HOLD, FLUSH, ERR} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_write_q, pc_write_d;
    logic               pc_wen_q, pc_wen_d;
    logic               imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic               fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               go_err;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        pc_write_d    = pc_write_q;
        pc_wen_d      = 1'b0;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        cnt_d         = (imem_req_q && !imem_ack) ? cnt_q + 1'b1 : '0;
        go_err        = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (!imem_req_q) begin
                    // Issue only once pc_in reflects the last pc_wen pulse.
                    if (!pc_wen_q) begin
                        imem_req_d  = 1'b1;
                        imem_addr_d = pc_in;
                    end
                end else if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = imem_addr_q;
                    instr_valid_d = 1'b1;
                    pc_write_d    = pc_in + ADDR_W'(PC_STEP);
                    pc_wen_d      = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (dec_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end
            end
            FLUSH: begin
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = REQ;
                end
            end
            default: ;
        endcase

        if (branch_taken && state_q != ERR) begin
            pc_write_d    = branch_target;
            pc_wen_d      = 1'b1;
            instr_d       = instr_q;
            instr_pc_d    = instr_pc_q;
            instr_valid_d = 1'b0;
            if (imem_req_q && !imem_ack) begin
                // Outstanding request must complete before refetching; keep it on the bus.
                state_d = FLUSH;
            end else begin
                imem_req_d  = 1'b0;
                imem_addr_d = imem_addr_q;
                state_d     = REQ;
            end
            if (branch_target[1:0] != 2'b00) go_err = 1'b1;
        end

        if (TIMEOUT != 0 && imem_req_q && !imem_ack && cnt_d == CNT_W'(TIMEOUT)) go_err = 1'b1;

        if (go_err) begin
            state_d       = ERR;
            pc_write_d    = '0;
            pc_wen_d      = 1'b0;
            imem_req_d    = 1'b0;
            imem_addr_d   = '0;
            instr_d       = '0;
            instr_pc_d    = '0;
            instr_valid_d = 1'b0;
            fetch_err_d   = 1'b1;
            cnt_d         = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_write_q    <= '0;
            pc_wen_q      <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_write_q    <= pc_write_d;
            pc_wen_q      <= pc_wen_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign pc_write    = pc_write_q;
    assign pc_wen      = pc_wen_q;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a PC register model plus hand-timed memory and
// decode stimulus, sampled on the falling edge.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] pc_in;
    logic [63:0] pc_write;
    logic        pc_wen;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        dec_ready = 1'b1;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic        fetch_err;

    logic        pc_load = 1'b0;
    logic [63:0] pc_load_val = '0;
    logic [63:0] pc_reg = '0;

    int total = 0;
    int bad = 0;

    instr_fetch_ctrl #(
        .ADDR_W(64), .INSTR_W(32), .PC_STEP(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_write(pc_write), .pc_wen(pc_wen),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .dec_ready(dec_ready), .branch_taken(branch_taken),
        .branch_target(branch_target), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_load) pc_reg <= pc_load_val;
        else if (pc_wen) pc_reg <= pc_write;
    end
    assign pc_in = pc_reg;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc_write"}, pc_write, 64'h0);
        check({tag, "_pc_wen"}, pc_wen, 0);
        check({tag, "_req"}, imem_req, 0);
        check({tag, "_addr"}, imem_addr, 64'h0);
        check({tag, "_instr"}, instr, 0);
        check({tag, "_instr_pc"}, instr_pc, 64'h0);
        check({tag, "_valid"}, instr_valid, 0);
    endtask

    initial begin
        #1;
        check_all_zero("rst");
        check("rst_err", fetch_err, 0);

        // First fetch at 0x0, memory answers one cycle after the request
        @(negedge clk); reset = 1'b1;
        step(); check("idle_no_req", imem_req, 0);
        step(); check("f0_req", imem_req, 1); check("f0_addr", imem_addr, 64'h0);
        step(); check("f0_req_held", imem_req, 1); check("f0_no_wen", pc_wen, 0);
        imem_ack = 1'b1; imem_rdata = 32'h8B02_0020;
        step(); imem_ack = 1'b0;
        check("f0_valid", instr_valid, 1); check("f0_instr", instr, 32'h8B02_0020);
        check("f0_instr_pc", instr_pc, 64'h0); check("f0_pc_write", pc_write, 64'h4);
        check("f0_wen", pc_wen, 1); check("f0_req_drop", imem_req, 0);
        step(); check("f0_wen_pulse", pc_wen, 0); check("f0_consumed", instr_valid, 0);
        check("f0_gap", imem_req, 0);

        // Second fetch at 0x4, decode stalls for 5 cycles
        step(); check("f1_req", imem_req, 1); check("f1_addr", imem_addr, 64'h4);
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        step(); imem_ack = 1'b0; dec_ready = 1'b0;
        check("f1_valid", instr_valid, 1); check("f1_instr", instr, 32'h1111_1111);
        check("f1_instr_pc", instr_pc, 64'h4); check("f1_pc_write", pc_write, 64'h8);
        check("f1_wen", pc_wen, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", instr_valid, 1); check("stall_instr", instr, 32'h1111_1111);
            check("stall_req", imem_req, 0); check("stall_wen", pc_wen, 0);
        end
        dec_ready = 1'b1;
        step(); check("resume_valid", instr_valid, 0); check("resume_gap", imem_req, 0);
        step(); check("f2_req", imem_req, 1); check("f2_addr", imem_addr, 64'h8);

        // Branch while waiting on memory: flush the late response
        branch_taken = 1'b1; branch_target = 64'h100;
        step(); branch_taken = 1'b0;
        check("br_wen", pc_wen, 1); check("br_pc_write", pc_write, 64'h100);
        check("br_req_held", imem_req, 1); check("br_addr_held", imem_addr, 64'h8);
        step(); check("br_wen_pulse", pc_wen, 0); check("flush_req", imem_req, 1);
        check("flush_valid", instr_valid, 0);
        step(); imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step(); imem_ack = 1'b0;
        check("flush_discard_valid", instr_valid, 0); check("flush_drop_req", imem_req, 0);
        check("flush_discard_instr", instr, 32'h1111_1111);
        step(); check("br_fetch_req", imem_req, 1); check("br_fetch_addr", imem_addr, 64'h100);

        // Ack and branch in the same cycle
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222; branch_taken = 1'b1; branch_target = 64'h40;
        step(); imem_ack = 1'b0; branch_taken = 1'b0;
        check("coll_valid", instr_valid, 0); check("coll_wen", pc_wen, 1);
        check("coll_pc_write", pc_write, 64'h40); check("coll_req", imem_req, 0);
        check("coll_instr", instr, 32'h1111_1111);
        step(); check("coll_wait_req", imem_req, 0); check("coll_wen_pulse", pc_wen, 0);
        step(); check("coll_req40", imem_req, 1); check("coll_addr40", imem_addr, 64'h40);
        imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        step(); imem_ack = 1'b0;
        check("f40_instr", instr, 32'h3333_3333); check("f40_instr_pc", instr_pc, 64'h40);
        check("f40_pc_write", pc_write, 64'h44); check("f40_valid", instr_valid, 1);
        step(2); check("f44_req", imem_req, 1); check("f44_addr", imem_addr, 64'h44);

        // Misaligned branch target -> sticky error
        branch_taken = 1'b1; branch_target = 64'h102;
        step(); branch_taken = 1'b0;
        check("mis_err", fetch_err, 1);
        check_all_zero("mis");
        branch_taken = 1'b1; branch_target = 64'h200;
        step(); branch_taken = 1'b0;
        check("err_no_wen", pc_wen, 0); check("err_pc_write", pc_write, 64'h0);
        check("err_sticky0", fetch_err, 1);
        step(2); check("err_sticky1", fetch_err, 1); check("err_req", imem_req, 0);
        reset = 1'b0; #1;
        check("rst2_err", fetch_err, 0);
        check_all_zero("rst2");

        // Memory never answers -> timeout after 8 request cycles
        @(negedge clk); reset = 1'b1;
        step(2); check("to_req", imem_req, 1); check("to_addr", imem_addr, 64'h44);
        step(7); check("to_not_yet", fetch_err, 0); check("to_req_still", imem_req, 1);
        step(); check("to_err", fetch_err, 1); check("to_req_drop", imem_req, 0);

        // PC wrap at top of address space, then branch squashing a held instruction
        reset = 1'b0; pc_load = 1'b1; pc_load_val = 64'hFFFF_FFFF_FFFF_FFFC;
        step(); pc_load = 1'b0; reset = 1'b1;
        step(2); check("wrap_req", imem_req, 1); check("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
        step(); imem_ack = 1'b0;
        check("wrap_pc_write", pc_write, 64'h0); check("wrap_wen", pc_wen, 1);
        check("wrap_instr", instr, 32'h4444_4444); check("wrap_instr_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        branch_taken = 1'b1; branch_target = 64'h80; dec_ready = 1'b1;
        step(); branch_taken = 1'b0;
        check("squash_valid", instr_valid, 0); check("squash_pc_write", pc_write, 64'h80);
        check("squash_wen", pc_wen, 1);
        step(); check("squash_wait", imem_req, 0);
        step(); check("squash_req", imem_req, 1); check("squash_addr", imem_addr, 64'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequencing controller that reads the program counter and drives its write port (pc_write/pc_wen). It issues instruction-memory requests at the current PC, captures returned instructions and hands them to decode over a valid/ready handshake. It also applies branch redirects and reports fetch errors. It sits between the PC register, instruction memory and the decode stage.

Parameters:
ADDR_W, 64, PC/address width.
INSTR_W, 32, instruction width.
PC_STEP, 4, sequential PC increment (bytes).
TIMEOUT, 255, max cycles waiting for imem_ack before error; 0 disables the timeout.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
pc_in  input  ADDR_W  current PC register value
pc_write  output  ADDR_W  next PC value to PC register
pc_wen  output  1  PC write enable; one-cycle pulse
imem_req  output  1  instruction memory request
imem_addr  output  ADDR_W  request address
imem_ack  input  1  memory response valid; imem_rdata valid this cycle
imem_rdata  input  INSTR_W  returned instruction
instr  output  INSTR_W  instruction to decode
instr_pc  output  ADDR_W  address of instr
instr_valid  output  1  instr/instr_pc valid
dec_ready  input  1  decode accepts instr this cycle
branch_taken  input  1  redirect pulse, one cycle
branch_target  input  ADDR_W  redirect address
fetch_err  output  1  sticky error flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs are 0: pc_write, pc_wen, imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err. Timeout counter = 0.
- PC timing: the PC register loads pc_write on the edge where pc_wen=1. pc_in shows the new value the next cycle. The controller never issues a request in the same cycle it pulses pc_wen.
- States: IDLE, REQ, HOLD, FLUSH, ERR.
- IDLE -> REQ after one cycle.
- REQ:
  - imem_req=1 and imem_addr=pc_in, held stable until imem_ack.
  - On imem_ack without branch: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc_write<=pc_in+PC_STEP (mod 2^ADDR_W, wraps silently), pc_wen<=1 for 1 cycle, imem_req<=0. Go to HOLD.
  - Latency: ack in cycle N gives instr_valid=1 from cycle N+1.
- HOLD:
  - instr, instr_pc and instr_valid are held stable while dec_ready=0.
  - On dec_ready=1: instr_valid<=0, go to REQ. Minimum 3 cycles per instruction with a zero-wait memory.
- Branch (branch_taken=1), in any state except ERR:
  - pc_write<=branch_target, pc_wen<=1. Branch has priority over the sequential update in the same cycle.
  - REQ with imem_ack in the same cycle: returned data is discarded, instr_valid stays 0, go to REQ after the pc_wen cycle.
  - REQ without ack: imem_req stays 1 (address unchanged), go to FLUSH. FLUSH waits for ack, discards the data, drops imem_req, then goes to REQ.
  - HOLD: instr_valid<=0 even if dec_ready=1 the same cycle (the instruction is squashed), go to REQ.
  - IDLE or FLUSH: pc_wen pulse, remain in or enter FLUSH/REQ as above.
- Misaligned target (branch_target[1:0]!=0): no pc_wen. fetch_err<=1, all requests drop, go to ERR.
- Timeout: counter increments each cycle imem_req=1 and imem_ack=0, and clears on ack. Reaching TIMEOUT (TIMEOUT!=0) sets fetch_err=1 and goes to ERR.
- ERR: all outputs except fetch_err are 0. fetch_err stays 1 and the state holds until reset.
- Reset mid-operation: immediate return to reset values. Any outstanding imem response after reset is ignored because imem_req=0.

Test Plan:
- Release reset with pc_in=0x0 and imem_ack one cycle after req, rdata=0x8B020020, dec_ready=1 -> imem_addr=0x0; instr=0x8B020020, instr_pc=0x0, instr_valid=1; pc_write=0x4 with a single pc_wen pulse; next request at 0x4.
- Hold dec_ready=0 for 5 cycles -> instr/instr_valid stable, no new imem_req, no pc_wen; raising dec_ready resumes with a request at pc_in.
- branch_taken with target 0x100 while in REQ waiting (ack 3 cycles later, rdata=0xDEADBEEF) -> pc_write=0x100 pulse, FLUSH, no instr_valid for 0xDEADBEEF, next imem_addr=0x100.
- Simultaneous imem_ack and branch_taken to 0x40 -> rdata discarded, only pc_write=0x40, next fetch at 0x40.
- branch_target=0x102 -> fetch_err=1, imem_req=0, no pc_wen; sticky until reset=0 pulse, then outputs 0.
- With TIMEOUT=8 and imem_ack never asserted -> fetch_err=1 after 8 req cycles; pc_in=0xFFFFFFFFFFFFFFFC with ack -> pc_write=0x0 (wrap).
